wb_order_arbiter: RTL and testbench

//  Writeback-stage arbiter directly downstream of the execution units and feeding the writeback instruction track FIFO.

---
 rtl/wb_order_arbiter_pkg.sv | 27 ++
 rtl/wb_order_fifo.sv | 52 +++++
 rtl/wb_order_arbiter.sv | 103 ++++++++++
 tb/tb_wb_order_arbiter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_order_arbiter_pkg.sv
// Shared types for the writeback order arbiter: unit codes, order-FIFO entry
// layout and default sizing.
package wb_order_arbiter_pkg;

  localparam int WB_UNIT_W  = 2;
  localparam int REG_AWIDTH = 5;
  localparam int WITF_DEPTH = 8;

  typedef enum logic [WB_UNIT_W-1:0] {
    WB_UNIT_ALU  = 2'd0,
    WB_UNIT_LSU  = 2'd1,
    WB_UNIT_MDU  = 2'd2,
    WB_UNIT_NONE = 2'd3
  } wb_unit_e;

  typedef struct packed {
    wb_unit_e                unit;
    logic [REG_AWIDTH-1:0]   rd;
    logic                    rdwen;
  } ord_entry_t;

  // x0 is hardwired to zero, so an entry only writes the regfile for rd != 0.
  function automatic logic writes_rd(input ord_entry_t e);
    return e.rdwen && (e.rd != '0);
  endfunction

endpackage

// File: rtl/wb_order_fifo.sv
// Program-order record of dispatched instructions: DEPTH x {unit, rd, rdwen}
// with wrap-flag pointers. The pointer MSB is the wrap flag.
module wb_order_fifo
  import wb_order_arbiter_pkg::*;
#(
  parameter int DEPTH = WITF_DEPTH
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       push,
  input  ord_entry_t push_entry,
  input  logic       pop,
  output ord_entry_t head,
  output logic       empty,
  output logic       full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  ord_entry_t  mem [DEPTH];
  logic [AW:0] wptr;
  logic [AW:0] rptr;

  always_comb begin
    empty = (wptr == rptr);
    full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  end

  assign head = mem[rptr[AW-1:0]];

  // Full is judged on registered pointers, so a push while full is dropped
  // even if the head retires in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full) begin
        mem[wptr[AW-1:0]] <= push_entry;
        wptr              <= wptr + PTR_ONE;
      end
      if (pop && !empty) rptr <= rptr + PTR_ONE;
    end
  end

endmodule

// File: rtl/wb_order_arbiter.sv
// Writeback arbiter: retires one execution-unit result per cycle in dispatch
// order, driving the regfile write port and the track-FIFO pop pulse.
module wb_order_arbiter
  import wb_order_arbiter_pkg::*;
#(
  parameter int DEPTH = WITF_DEPTH,
  parameter int XLEN  = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  disp_fire,
  input  logic [WB_UNIT_W-1:0]  disp_unit,
  input  logic [REG_AWIDTH-1:0] disp_rd,
  input  logic                  disp_rdwen,
  output logic                  ord_full,
  input  logic                  alu_vld,
  input  logic                  lsu_vld,
  input  logic                  mdu_vld,
  output logic                  alu_rdy,
  output logic                  lsu_rdy,
  output logic                  mdu_rdy,
  input  logic [XLEN-1:0]       alu_wdata,
  input  logic [XLEN-1:0]       lsu_wdata,
  input  logic [XLEN-1:0]       mdu_wdata,
  output logic                  rf_wen,
  output logic [REG_AWIDTH-1:0] rf_waddr,
  output logic [XLEN-1:0]       rf_wdata,
  output logic                  wb_en
);

  ord_entry_t      push_entry;
  ord_entry_t      head;
  logic            empty;
  logic            full;
  logic            retire;
  logic [XLEN-1:0] sel_wdata;

  assign push_entry = '{unit: wb_unit_e'(disp_unit), rd: disp_rd, rdwen: disp_rdwen};
  assign ord_full   = full;

  wb_order_fifo #(.DEPTH(DEPTH)) u_order_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .push       (disp_fire && !flush),
    .push_entry (push_entry),
    .pop        (retire),
    .head       (head),
    .empty      (empty),
    .full       (full)
  );

  // Handshake: a unit raises X_vld with X_wdata and holds both stable until it
  // sees X_rdy; the result transfers in the cycle where X_vld && X_rdy. Only the
  // unit owning the head entry ever sees rdy, and never during flush.
  always_comb begin
    alu_rdy   = 1'b0;
    lsu_rdy   = 1'b0;
    mdu_rdy   = 1'b0;
    retire    = 1'b0;
    sel_wdata = '0;
    if (!empty && !flush) begin
      case (head.unit)
        WB_UNIT_ALU: begin
          alu_rdy   = 1'b1;
          retire    = alu_vld;
          sel_wdata = alu_wdata;
        end
        WB_UNIT_LSU: begin
          lsu_rdy   = 1'b1;
          retire    = lsu_vld;
          sel_wdata = lsu_wdata;
        end
        WB_UNIT_MDU: begin
          mdu_rdy   = 1'b1;
          retire    = mdu_vld;
          sel_wdata = mdu_wdata;
        end
        default: ;
      endcase
    end
  end

  // wb_en pulses for every retirement, x0 included, to keep the track FIFO's
  // read pointer in step; waddr/wdata hold between retirements.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_en    <= 1'b0;
      rf_wen   <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      wb_en  <= retire;
      rf_wen <= retire && writes_rd(head);
      if (retire) begin
        rf_waddr <= head.rd;
        rf_wdata <= sel_wdata;
      end
    end
  end

endmodule

// File: tb/tb_wb_order_arbiter.sv
// Self-checking bench for wb_order_arbiter: directed scenarios plus random
// dispatch/completion traffic against a queue-based program-order model.
module tb_wb_order_arbiter;

  localparam int DEPTH = 4;
  localparam int W     = 69;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        flush, disp_fire, disp_rdwen, ord_full;
  logic [1:0]  disp_unit;
  logic [4:0]  disp_rd;
  logic [2:0]  vld;
  logic        alu_rdy, lsu_rdy, mdu_rdy;
  logic [63:0] wd [3];
  logic        rf_wen, wb_en;
  logic [4:0]  rf_waddr;
  logic [63:0] rf_wdata;

  wb_order_arbiter #(.DEPTH(DEPTH), .XLEN(64)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .disp_fire(disp_fire), .disp_unit(disp_unit), .disp_rd(disp_rd),
    .disp_rdwen(disp_rdwen), .ord_full(ord_full),
    .alu_vld(vld[0]), .lsu_vld(vld[1]), .mdu_vld(vld[2]),
    .alu_rdy(alu_rdy), .lsu_rdy(lsu_rdy), .mdu_rdy(mdu_rdy),
    .alu_wdata(wd[0]), .lsu_wdata(wd[1]), .mdu_wdata(wd[2]),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .wb_en(wb_en)
  );

  // reference model: in-flight instructions in program order
  typedef struct {
    int          unit;
    int          rd;
    bit          rdwen;
    logic [63:0] data;
  } ent_t;

  ent_t        mq[$];
  logic [W-1:0] exp_q[$];
  logic        exp_wb, exp_wen;
  logic [4:0]  exp_waddr;
  logic [63:0] exp_wdata;
  logic [63:0] disp_data;
  int          mode[3];
  bit          held[3];
  int          n_tests = 0, n_fail = 0;
  int          push_count, flushed, wb_count, cyc_n;
  logic [4:0]  obs_addr[$];
  logic [63:0] obs_data[$];
  int          obs_cyc[$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int first_idx(input int u);
    for (int i = 0; i < mq.size(); i++) if (mq[i].unit == u) return i;
    return -1;
  endfunction

  task automatic model_reset();
    mq.delete();
    exp_q.delete();
    exp_wb = 0; exp_wen = 0; exp_waddr = '0; exp_wdata = '0;
    for (int u = 0; u < 3; u++) held[u] = 0;
    push_count = 0; flushed = 0; wb_count = 0;
  endtask

  // unit driver: a unit offers its oldest outstanding result, holding it once offered
  task automatic drive();
    int  i;
    bit  v;
    for (int u = 0; u < 3; u++) begin
      i = first_idx(u);
      v = held[u] || (i >= 0 && (mode[u] == 1 || (mode[u] == 2 && $urandom_range(0, 99) < 50)));
      if (i < 0) v = 0;
      vld[u] = v;
      wd[u]  = v ? mq[i].data : 64'h0;
    end
  endtask

  // one clock: check outputs at negedge, advance model, step past posedge
  task automatic tick();
    int   sz, hu, w;
    bit   ret;
    ent_t e;
    @(negedge clk);
    cyc_n++;
    check("wb_en", wb_en, exp_wb);
    check("rf_wen", rf_wen, exp_wen);
    check("rf_waddr", rf_waddr, exp_waddr);
    check("rf_wdata", rf_wdata, exp_wdata);
    check("ord_full", ord_full, mq.size() == DEPTH);
    if (wb_en === 1'b1) wb_count++;
    if (rf_wen === 1'b1) begin
      obs_addr.push_back(rf_waddr);
      obs_data.push_back(rf_wdata);
      obs_cyc.push_back(cyc_n);
      if (exp_q.size() == 0) check("sb_extra_write", rf_wen, 1'b0);
      else check("sb_write", {rf_waddr, rf_wdata}, exp_q.pop_front());
    end
    check("rdy_onehot", (32'(alu_rdy) + 32'(lsu_rdy) + 32'(mdu_rdy)) <= 1, 1'b1);
    if (disp_fire) check("disp_while_full", ord_full, 1'b0);
    sz = mq.size();
    hu = (sz > 0 && !flush) ? mq[0].unit : 3;
    check("alu_rdy", alu_rdy, hu == 0);
    check("lsu_rdy", lsu_rdy, hu == 1);
    check("mdu_rdy", mdu_rdy, hu == 2);
    ret = (hu < 3) && vld[hu];
    for (int u = 0; u < 3; u++)
      held[u] = vld[u] && !(ret && hu == u) && !flush && first_idx(u) >= 0;
    if (ret) begin
      e = mq.pop_front();
      exp_wb = 1; exp_wen = e.rdwen && e.rd != 0;
      exp_waddr = e.rd[4:0]; exp_wdata = e.data;
    end else begin
      exp_wb = 0; exp_wen = 0;
    end
    if (flush) begin
      w = 0;
      foreach (mq[i]) if (mq[i].rdwen && mq[i].rd != 0) w++;
      repeat (w) void'(exp_q.pop_back());
      flushed += mq.size();
      mq.delete();
    end else if (disp_fire && sz < DEPTH) begin
      e.unit = int'(disp_unit); e.rd = int'(disp_rd); e.rdwen = disp_rdwen; e.data = disp_data;
      mq.push_back(e);
      push_count++;
      if (e.rdwen && e.rd != 0) exp_q.push_back({disp_rd, disp_data});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input bit fire, input int unit, input int rd, input bit rdwen, input logic [63:0] data);
    disp_fire = fire; disp_unit = unit[1:0]; disp_rd = rd[4:0];
    disp_rdwen = rdwen; disp_data = data;
    drive();
    tick();
    disp_fire = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    rst = 0; flush = 0; disp_fire = 0; disp_unit = 0; disp_rd = 0; disp_rdwen = 0;
    disp_data = 0; vld = '0; wd[0] = 0; wd[1] = 0; wd[2] = 0; cyc_n = 0;
    for (int u = 0; u < 3; u++) mode[u] = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_wb_en", wb_en, 1'b0);
    check("rst_rf_wen", rf_wen, 1'b0);
    check("rst_rf_waddr", rf_waddr, 5'd0);
    check("rst_rf_wdata", rf_wdata, 64'd0);
    check("rst_ord_full", ord_full, 1'b0);
    rst = 1;

    // 1: reset mid-stream with two entries queued
    cyc(1, 0, 1, 1, 64'h101);
    cyc(1, 0, 2, 1, 64'h102);
    mode[0] = 1;
    cyc(0, 0, 0, 0, 0);
    #1;
    check("t1_pre_rst_wb_en", wb_en, 1'b1);
    rst = 0;
    #1;
    check("t1_rst_wb_en", wb_en, 1'b0);
    check("t1_rst_rf_wen", rf_wen, 1'b0);
    model_reset();
    mode[0] = 0;
    @(posedge clk);
    #1;
    rst = 1;
    vld[0] = 1; wd[0] = 64'hdead;
    #1;
    check("t1_alu_rdy_empty", alu_rdy, 1'b0);
    check("t1_ord_full", ord_full, 1'b0);
    vld[0] = 0;

    // 2: LSU result arrives before older ALU result
    obs_addr.delete(); obs_data.delete(); obs_cyc.delete();
    cyc(1, 0, 5, 1, 64'h11);
    cyc(1, 1, 6, 1, 64'hAA);
    mode[1] = 1;
    repeat (3) begin
      drive();
      #1;
      check("t2_lsu_vld", vld[1], 1'b1);
      check("t2_lsu_rdy_wait", lsu_rdy, 1'b0);
      tick();
    end
    mode[0] = 1;
    repeat (4) cyc(0, 0, 0, 0, 0);
    check("t2_nwrites", obs_addr.size(), 2);
    if (obs_addr.size() >= 2) begin
      check("t2_w0_addr", obs_addr[0], 5'd5);
      check("t2_w0_data", obs_data[0], 64'h11);
      check("t2_w1_addr", obs_addr[1], 5'd6);
      check("t2_w1_data", obs_data[1], 64'hAA);
      check("t2_consecutive", obs_cyc[1] - obs_cyc[0], 1);
    end
    mode[0] = 0; mode[1] = 0;

    // 3: fill, then simultaneous push/retire across several wraps
    for (int i = 0; i < DEPTH; i++) cyc(1, 0, 10 + i, 1, {$urandom, $urandom});
    check("t3_full", ord_full, 1'b1);
    mode[0] = 1;
    cyc(0, 0, 0, 0, 0);
    check("t3_slot_freed", ord_full, 1'b0);
    for (int i = 0; i < 2 * DEPTH * 2; i++) cyc(1, 0, $urandom_range(1, 31), 1, {$urandom, $urandom});
    check("t3_occupancy", mq.size(), DEPTH - 1);
    mode[0] = 0;
    cyc(1, 0, 20, 1, 64'h2020);
    check("t3_refull", ord_full, 1'b1);
    mode[0] = 1;
    repeat (DEPTH + 2) cyc(0, 0, 0, 0, 0);
    check("t3_sb_drained", exp_q.size(), 0);
    check("t3_wb_vs_push", wb_count, push_count - flushed);
    mode[0] = 0;

    // 4: x0 and no-rdwen writes still pop the track FIFO
    w0 = wb_count;
    obs_addr.delete(); obs_data.delete(); obs_cyc.delete();
    cyc(1, 2, 0, 1, 64'h55);
    cyc(1, 0, 7, 0, 64'h77);
    mode[0] = 1; mode[2] = 1;
    repeat (4) cyc(0, 0, 0, 0, 0);
    check("t4_wb_pulses", wb_count - w0, 2);
    check("t4_rf_wen_count", obs_addr.size(), 0);
    mode[0] = 0; mode[2] = 0;

    // 5: flush with the head's result valid
    for (int i = 0; i < 3; i++) cyc(1, 0, 3, 1, 64'h300 + 64'(i));
    mode[0] = 1;
    flush = 1;
    drive();
    #1;
    check("t5_alu_vld_in_flush", vld[0], 1'b1);
    check("t5_alu_rdy_in_flush", alu_rdy, 1'b0);
    tick();
    flush = 0;
    w0 = wb_count;
    cyc(0, 0, 0, 0, 0);
    check("t5_no_wb_after_flush", wb_count - w0, 0);
    check("t5_empty", ord_full, 1'b0);
    obs_addr.delete(); obs_data.delete(); obs_cyc.delete();
    cyc(1, 0, 9, 1, 64'h99);
    repeat (3) cyc(0, 0, 0, 0, 0);
    check("t5_nwrites", obs_addr.size(), 1);
    if (obs_addr.size() >= 1) begin
      check("t5_addr", obs_addr[0], 5'd9);
      check("t5_data", obs_data[0], 64'h99);
    end

    // 6: random traffic
    for (int u = 0; u < 3; u++) mode[u] = 2;
    for (int n = 0; n < 600; n++) begin
      flush = ($urandom_range(0, 99) < 2);
      cyc((mq.size() < DEPTH) && ($urandom_range(0, 99) < 60), $urandom_range(0, 2),
          $urandom_range(0, 31), $urandom_range(0, 3) != 0, {$urandom, $urandom});
      flush = 0;
    end
    for (int u = 0; u < 3; u++) mode[u] = 1;
    for (int k = 0; k < 64 && mq.size() > 0; k++) cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    check("t6_drained", mq.size(), 0);
    check("t6_sb_empty", exp_q.size(), 0);
    check("t6_wb_vs_push", wb_count, push_count - flushed);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
